// File: rtl/warp_scheduler.sv
// rtl/warp_scheduler.sv - round-robin warp scheduler with a single issue slot
// Tracks per-warp state/PC, issues READY warps, and handles retire and memory-completion events.
module warp_scheduler #(
   parameter int NUM_WARPS = 4,
   parameter int PC_BITS   = 8,
   localparam int WID      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int CW       = $clog2(NUM_WARPS) + 1
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 start_i,
   input  logic [CW-1:0]        warp_count_i,
   output logic                 issue_valid_o,
   output logic [WID-1:0]       issue_warp_o,
   output logic [PC_BITS-1:0]   issue_pc_o,
   input  logic                 issue_ready_i,
   input  logic                 retire_valid_i,
   input  logic [WID-1:0]       retire_warp_i,
   input  logic [PC_BITS-1:0]   retire_next_pc_i,
   input  logic                 retire_ret_i,
   input  logic                 retire_mem_i,
   input  logic                 mem_done_valid_i,
   input  logic [WID-1:0]       mem_done_warp_i,
   output logic [NUM_WARPS-1:0] warp_done_o,
   output logic                 done_o,
   output logic                 protocol_error_o
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_e;
   typedef enum logic [2:0] {W_IDLE, W_READY, W_ISSUED, W_WAIT_MEM, W_DONE} wstate_e;

   fsm_e                 fsm_q, fsm_d;
   wstate_e              ws_q [NUM_WARPS];
   wstate_e              ws_d [NUM_WARPS];
   logic [PC_BITS-1:0]   pc_q [NUM_WARPS];
   logic [PC_BITS-1:0]   pc_d [NUM_WARPS];
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WID-1:0]       rr_q, rr_d;
   logic                 vld_q, vld_d;
   logic [WID-1:0]       iw_q, iw_d;
   logic [PC_BITS-1:0]   ipc_q, ipc_d;
   logic [NUM_WARPS-1:0] wd_q, wd_d;
   logic                 done_q, done_d;
   logic                 perr_q, perr_d;

   logic                 sel_found;
   logic [WID-1:0]       sel_idx;
   logic                 all_done;
   logic                 ret_ok;
   logic                 mem_ok;
   logic [CW-1:0]        cnt_clamp;

   // First READY warp at or after rr_q, looking only at registered state.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 0; k < NUM_WARPS; k++) begin
         if (!sel_found && ws_q[(int'(rr_q) + k) % NUM_WARPS] == W_READY) begin
            sel_found = 1'b1;
            sel_idx   = WID'((int'(rr_q) + k) % NUM_WARPS);
         end
      end
   end

   always_comb begin
      all_done = 1'b1;
      for (int i = 0; i < NUM_WARPS; i++) begin
         if (i < int'(cnt_q) && ws_q[i] != W_DONE) all_done = 1'b0;
      end
   end

   // A warp still sitting in the slot has not reached the pipeline, so it cannot retire.
   assign ret_ok = (fsm_q == S_RUN) && (int'(retire_warp_i) < int'(cnt_q)) &&
                   (ws_q[retire_warp_i] == W_ISSUED) &&
                   !(vld_q && iw_q == retire_warp_i);
   assign mem_ok = (fsm_q == S_RUN) && (int'(mem_done_warp_i) < int'(cnt_q)) &&
                   (ws_q[mem_done_warp_i] == W_WAIT_MEM);
   assign cnt_clamp = (int'(warp_count_i) > NUM_WARPS) ? CW'(NUM_WARPS) : warp_count_i;

   always_comb begin
      fsm_d  = fsm_q;
      cnt_d  = cnt_q;
      rr_d   = rr_q;
      vld_d  = vld_q;
      iw_d   = iw_q;
      ipc_d  = ipc_q;
      wd_d   = wd_q;
      perr_d = perr_q;
      for (int i = 0; i < NUM_WARPS; i++) begin
         ws_d[i] = ws_q[i];
         pc_d[i] = pc_q[i];
      end

      if ((retire_valid_i && !ret_ok) || (mem_done_valid_i && !mem_ok)) perr_d = 1'b1;

      unique case (fsm_q)
         S_IDLE: begin
            if (start_i) begin
               fsm_d = S_RUN;
               cnt_d = cnt_clamp;
               for (int i = 0; i < NUM_WARPS; i++) begin
                  if (i < int'(cnt_clamp)) begin
                     ws_d[i] = W_READY;
                     pc_d[i] = '0;
                  end
               end
            end
         end
         S_RUN: begin
            if (retire_valid_i && ret_ok) begin
               if (retire_ret_i) begin
                  ws_d[retire_warp_i] = W_DONE;
                  wd_d[retire_warp_i] = 1'b1;
               end else begin
                  ws_d[retire_warp_i] = retire_mem_i ? W_WAIT_MEM : W_READY;
                  pc_d[retire_warp_i] = retire_next_pc_i;
               end
            end
            if (mem_done_valid_i && mem_ok) ws_d[mem_done_warp_i] = W_READY;
            if (!vld_q || issue_ready_i) begin
               vld_d = sel_found;
               if (sel_found) begin
                  iw_d          = sel_idx;
                  ipc_d         = pc_q[sel_idx];
                  ws_d[sel_idx] = W_ISSUED;
                  rr_d          = WID'((int'(sel_idx) + 1) % NUM_WARPS);
               end
            end
            if (all_done) fsm_d = S_DONE;
         end
         default: ;
      endcase

      if (fsm_d != S_RUN) vld_d = 1'b0;
      done_d = (fsm_d == S_DONE);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         fsm_q  <= S_IDLE;
         cnt_q  <= '0;
         rr_q   <= '0;
         vld_q  <= 1'b0;
         iw_q   <= '0;
         ipc_q  <= '0;
         wd_q   <= '0;
         done_q <= 1'b0;
         perr_q <= 1'b0;
         for (int i = 0; i < NUM_WARPS; i++) begin
            ws_q[i] <= W_IDLE;
            pc_q[i] <= '0;
         end
      end else begin
         fsm_q  <= fsm_d;
         cnt_q  <= cnt_d;
         rr_q   <= rr_d;
         vld_q  <= vld_d;
         iw_q   <= iw_d;
         ipc_q  <= ipc_d;
         wd_q   <= wd_d;
         done_q <= done_d;
         perr_q <= perr_d;
         for (int i = 0; i < NUM_WARPS; i++) begin
            ws_q[i] <= ws_d[i];
            pc_q[i] <= pc_d[i];
         end
      end
   end

   assign issue_valid_o    = vld_q;
   assign issue_warp_o     = iw_q;
   assign issue_pc_o       = ipc_q;
   assign warp_done_o      = wd_q;
   assign done_o           = done_q;
   assign protocol_error_o = perr_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// tb/tb_warp_scheduler.sv - directed self-checking bench for warp_scheduler
// Linear directed scenario: launch, memory park, backpressure, completion, zero-count launch and mid-run reset.
module tb_warp_scheduler;

   logic       clk_i = 1'b0;
   logic       reset_ni;
   logic       start_i;
   logic [2:0] warp_count_i;
   logic       issue_valid_o;
   logic [1:0] issue_warp_o;
   logic [7:0] issue_pc_o;
   logic       issue_ready_i;
   logic       retire_valid_i;
   logic [1:0] retire_warp_i;
   logic [7:0] retire_next_pc_i;
   logic       retire_ret_i;
   logic       retire_mem_i;
   logic       mem_done_valid_i;
   logic [1:0] mem_done_warp_i;
   logic [3:0] warp_done_o;
   logic       done_o;
   logic       protocol_error_o;

   int checks   = 0;
   int failures = 0;

   warp_scheduler #(.NUM_WARPS(4), .PC_BITS(8)) dut (
      .clk_i            (clk_i),
      .reset_ni         (reset_ni),
      .start_i          (start_i),
      .warp_count_i     (warp_count_i),
      .issue_valid_o    (issue_valid_o),
      .issue_warp_o     (issue_warp_o),
      .issue_pc_o       (issue_pc_o),
      .issue_ready_i    (issue_ready_i),
      .retire_valid_i   (retire_valid_i),
      .retire_warp_i    (retire_warp_i),
      .retire_next_pc_i (retire_next_pc_i),
      .retire_ret_i     (retire_ret_i),
      .retire_mem_i     (retire_mem_i),
      .mem_done_valid_i (mem_done_valid_i),
      .mem_done_warp_i  (mem_done_warp_i),
      .warp_done_o      (warp_done_o),
      .done_o           (done_o),
      .protocol_error_o (protocol_error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_slot(input string tag, input logic v, input logic [1:0] w, input logic [7:0] pc);
      chk({tag, "_valid"}, 32'(issue_valid_o), 32'(v));
      if (v) begin
         chk({tag, "_warp"}, 32'(issue_warp_o), 32'(w));
         chk({tag, "_pc"}, 32'(issue_pc_o), 32'(pc));
      end
   endtask

   task automatic retire(input logic [1:0] w, input logic [7:0] pc, input logic ret, input logic mem);
      retire_valid_i   = 1'b1;
      retire_warp_i    = w;
      retire_next_pc_i = pc;
      retire_ret_i     = ret;
      retire_mem_i     = mem;
   endtask

   task automatic retire_off();
      retire_valid_i = 1'b0;
      retire_ret_i   = 1'b0;
      retire_mem_i   = 1'b0;
   endtask

   initial begin
      reset_ni = 1'b0; start_i = 1'b0; warp_count_i = '0; issue_ready_i = 1'b1;
      retire_valid_i = 1'b0; retire_warp_i = '0; retire_next_pc_i = '0;
      retire_ret_i = 1'b0; retire_mem_i = 1'b0; mem_done_valid_i = 1'b0; mem_done_warp_i = '0;
      #3;
      chk("rst_valid", 32'(issue_valid_o), 0);
      chk("rst_warp", 32'(issue_warp_o), 0);
      chk("rst_pc", 32'(issue_pc_o), 0);
      chk("rst_wdone", 32'(warp_done_o), 0);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_perr", 32'(protocol_error_o), 0);
      step(); step();
      reset_ni = 1'b1;

      // Launch three warps with ready held high.
      start_i = 1'b1; warp_count_i = 3'd3;
      step();
      start_i = 1'b0;
      chk_slot("launch_e0", 0, 0, 0);
      step(); chk_slot("issue_w0", 1, 0, 8'd0);
      step(); chk_slot("issue_w1", 1, 1, 8'd0);
      step(); chk_slot("issue_w2", 1, 2, 8'd0);
      step(); chk_slot("no_w3", 0, 0, 0);

      // Warp 0 parks on memory, warps 1 and 2 come back READY.
      retire(0, 8'd5, 0, 1);
      step(); chk_slot("park_w0", 0, 0, 0);
      retire(1, 8'd3, 0, 0);
      step(); chk_slot("ret_w1_lat", 0, 0, 0);
      retire(2, 8'd7, 0, 0);
      step(); chk_slot("reissue_w1", 1, 1, 8'd3);
      retire_off();
      step(); chk_slot("reissue_w2", 1, 2, 8'd7);
      mem_done_valid_i = 1'b1; mem_done_warp_i = 2'd0;
      step();
      mem_done_valid_i = 1'b0;
      chk_slot("mem_lat", 0, 0, 0);
      step(); chk_slot("reissue_w0", 1, 0, 8'd5);

      // Backpressure for four cycles while warps 1 and 2 become READY.
      issue_ready_i = 1'b0;
      retire(1, 8'd9, 0, 0);
      step(); chk_slot("hold1", 1, 0, 8'd5);
      retire(2, 8'd11, 0, 0);
      step(); chk_slot("hold2", 1, 0, 8'd5);
      retire_off();
      step(); chk_slot("hold3", 1, 0, 8'd5);
      step(); chk_slot("hold4", 1, 0, 8'd5);
      issue_ready_i = 1'b1;
      step(); chk_slot("resume_w1", 1, 1, 8'd9);
      step(); chk_slot("resume_w2", 1, 2, 8'd11);
      step(); chk_slot("drain", 0, 0, 0);

      // Retire of an IDLE warp is illegal and changes nothing else.
      retire(3, 8'd0, 1, 0);
      step();
      chk("idle_ret_perr", 32'(protocol_error_o), 1);
      chk("idle_ret_wdone", 32'(warp_done_o), 0);
      chk_slot("idle_ret_slot", 0, 0, 0);

      // All three warps finish.
      retire(0, 8'd0, 1, 0);
      step(); chk("wdone_0", 32'(warp_done_o), 32'h1);
      retire(1, 8'd0, 1, 1);
      step(); chk("wdone_01", 32'(warp_done_o), 32'h3);
      retire(2, 8'd0, 1, 0);
      step();
      retire_off();
      chk("wdone_012", 32'(warp_done_o), 32'h7);
      chk("done_not_yet", 32'(done_o), 0);
      step(); chk("done_high", 32'(done_o), 1);
      start_i = 1'b1; warp_count_i = 3'd2;
      step();
      start_i = 1'b0;
      chk("done_hold", 32'(done_o), 1);
      chk("done_wdone", 32'(warp_done_o), 32'h7);
      chk_slot("done_noissue", 0, 0, 0);

      // Asynchronous reset clears outputs before any edge.
      #2 reset_ni = 1'b0;
      #1;
      chk("arst_done", 32'(done_o), 0);
      chk("arst_wdone", 32'(warp_done_o), 0);
      chk("arst_perr", 32'(protocol_error_o), 0);
      step();
      reset_ni = 1'b1;

      // Launch with zero warps.
      start_i = 1'b1; warp_count_i = 3'd0;
      step();
      start_i = 1'b0;
      chk_slot("zero_e0", 0, 0, 0);
      step();
      chk("zero_done", 32'(done_o), 1);
      chk_slot("zero_e1", 0, 0, 0);
      step(); chk_slot("zero_e2", 0, 0, 0);

      // Mid-run reset with warp 1 parked on memory and warp 0 in the slot.
      reset_ni = 1'b0;
      step();
      reset_ni = 1'b1;
      start_i = 1'b1; warp_count_i = 3'd2;
      step();
      start_i = 1'b0;
      step(); chk_slot("r2_w0", 1, 0, 8'd0);
      step(); chk_slot("r2_w1", 1, 1, 8'd0);
      step(); chk_slot("r2_drain", 0, 0, 0);
      retire(1, 8'd4, 0, 1);
      step();
      retire(0, 8'd2, 0, 0);
      step();
      retire_off();
      mem_done_valid_i = 1'b1; mem_done_warp_i = 2'd3;
      step();
      mem_done_valid_i = 1'b0;
      chk_slot("r2_w0_pc2", 1, 0, 8'd2);
      chk("r2_perr", 32'(protocol_error_o), 1);
      #2 reset_ni = 1'b0;
      #1;
      chk("arst2_valid", 32'(issue_valid_o), 0);
      chk("arst2_warp", 32'(issue_warp_o), 0);
      chk("arst2_pc", 32'(issue_pc_o), 0);
      chk("arst2_perr", 32'(protocol_error_o), 0);
      chk("arst2_done", 32'(done_o), 0);
      step();
      reset_ni = 1'b1;

      // Relaunch with an over-range count, clamped to four warps.
      start_i = 1'b1; warp_count_i = 3'd7;
      step();
      start_i = 1'b0;
      step(); chk_slot("r3_w0", 1, 0, 8'd0);
      step(); chk_slot("r3_w1", 1, 1, 8'd0);
      step(); chk_slot("r3_w2", 1, 2, 8'd0);
      step(); chk_slot("r3_w3", 1, 3, 8'd0);
      step(); chk_slot("r3_drain", 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/warp_scheduler.md
WARP_SCHEDULER -- requirements
Module: warp_scheduler

Interface
REQ-001 The block SHALL take parameter NUM_WARPS, default 4, the number of warp contexts.
REQ-002 The block SHALL take parameter PC_BITS, default 8, the program-counter width.
REQ-003 The block SHALL use WID = max(1, clog2(NUM_WARPS)) as the warp-index width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  kernel launch pulse.
REQ-007 warp_count  input  clog2(NUM_WARPS)+1  number of active warps; sampled on an accepted start.
REQ-008 issue_valid  output  1  the issue slot holds a warp.
REQ-009 issue_warp  output  WID  warp held in the slot.
REQ-010 issue_pc  output  PC_BITS  PC of that warp.
REQ-011 issue_ready  input  1  pipeline accepts the slot this cycle.
REQ-012 retire_valid  input  1  an issued warp has finished its instruction.
REQ-013 retire_warp  input  WID  retiring warp.
REQ-014 retire_next_pc  input  PC_BITS  next PC of the retiring warp.
REQ-015 retire_ret  input  1  the retiring instruction was RET.
REQ-016 retire_mem  input  1  the retiring warp is parked on an outstanding memory access.
REQ-017 mem_done_valid  input  1  memory completion pulse.
REQ-018 mem_done_warp  input  WID  warp whose memory access completed.
REQ-019 warp_done  output  NUM_WARPS  per-warp finished flags.
REQ-020 done  output  1  all active warps finished.
REQ-021 protocol_error  output  1  sticky flag for an illegal retire or mem_done event.

Function
REQ-022 Each warp SHALL hold a state register: IDLE, READY, ISSUED, WAIT_MEM or DONE.
- Each warp SHALL also hold a PC_BITS program-counter register.
REQ-023 The top-level FSM SHALL have three states, with these transitions:
- S_IDLE -> S_RUN on start.
- S_RUN -> S_DONE when every active warp is DONE.
- S_DONE is held until reset.
- start SHALL be ignored outside S_IDLE.
REQ-024 On start in S_IDLE, the block SHALL do all of the following on that edge:
- Warps 0..warp_count-1 go to READY with PC 0.
- The remaining warps stay IDLE.
- warp_count is clamped to NUM_WARPS.
REQ-025 If start arrives with warp_count=0, the block SHALL enter S_DONE on the next edge.
REQ-026 The slot SHALL load on any edge in S_RUN where it is empty, or is being accepted (issue_valid && issue_ready), and some warp is READY.
- The loaded warp's state SHALL become ISSUED on that same edge.
- Otherwise, on acceptance the slot SHALL empty.
REQ-027 Selection SHALL be round-robin, using this rule:
- Choose the first READY warp at index >= rr_ptr, wrapping modulo NUM_WARPS.
- rr_ptr SHALL become (loaded index + 1) mod NUM_WARPS on each load.
- rr_ptr SHALL reset to 0.
REQ-028 While issue_valid=1 and issue_ready=0, issue_warp and issue_pc SHALL hold stable.
REQ-029 Selection SHALL use only registered warp states; a warp made READY on edge N is eligible on edge N+1 at the earliest.
REQ-030 Retire SHALL apply only to a warp in ISSUED that is not currently in the slot, as follows:
- retire_ret=1: state -> DONE and its warp_done bit set (retire_ret has priority over retire_mem).
- retire_mem=1: state -> WAIT_MEM, PC <= retire_next_pc.
- Otherwise: state -> READY, PC <= retire_next_pc.
REQ-031 mem_done SHALL move a WAIT_MEM warp to READY with its PC unchanged.
REQ-032 Simultaneous retire and mem_done events on different warps SHALL both take effect on the same edge.
REQ-033 An illegal event SHALL set protocol_error and change no other state. Illegal events are:
- A retire on a warp that is not ISSUED, or is in the slot.
- A mem_done on a warp that is not WAIT_MEM.
- A warp index >= warp_count.
- Any retire or mem_done outside S_RUN.
REQ-034 done SHALL be registered and equal 1 exactly while in S_DONE.
REQ-035 issue_valid SHALL be 0 outside S_RUN.

Reset
REQ-036 Reset low SHALL asynchronously clear every register:
- FSM -> S_IDLE, all warps IDLE, all PCs 0, rr_ptr 0, slot empty.
- issue_valid=0, issue_warp=0, issue_pc=0, warp_done=0, done=0, protocol_error=0.
REQ-037 Reset asserted mid-kernel SHALL abandon all warp contexts; a new start SHALL be required.

Verification
REQ-038 Launch with warp_count=3 (NUM_WARPS=4) and issue_ready held 1 -> issues warp 0, 1, 2 on consecutive cycles, all at pc 0; warp 3 is never issued.
REQ-039 Warp 0 retires with retire_mem=1 and next_pc=5; warps 1 and 2 continue -> warp 0 is skipped; after mem_done_warp=0 it reissues at pc 5 no earlier than 2 cycles after the pulse.
REQ-040 issue_ready held 0 for 4 cycles while warps 1 and 2 become READY -> issue_warp and issue_pc stay frozen, then round-robin resumes from the frozen index + 1.
REQ-041 All 3 warps retire with retire_ret=1 -> warp_done=4'b0111; done rises one edge after the last retire and stays high; a later start is ignored.
REQ-042 Boundary and error cases:
- start with warp_count=0 -> done=1 after one edge, no issue.
- retire of an IDLE warp -> protocol_error=1, other state unchanged.
REQ-043 Reset pulsed low mid-run with warp 1 in WAIT_MEM -> all outputs are 0 immediately, without waiting for a clock edge; a new start relaunches cleanly.
